pipeline_control_unit: RTL and testbench

Sequencing and hazard controller for the five-stage MIPS pipeline. It owns the global stage enable and decides which cycles the pipeline advances: continuous run, single-step, pause, and terminal stop on a HALT instruction reaching WB. It also detects load-use hazards and taken-branch flushes around the decode stage, and drives the PC and IF/ID enables plus the IF/ID and ID/EX flushes. Commands arrive from the debug unit over a valid/ready handshake.

---
 rtl/pipeline_control_unit_pkg.sv | 18 +
 rtl/pipeline_control_unit_hazard_detector.sv | 15 +
 rtl/pipeline_control_unit.sv | 72 +++++++
 tb/tb_pipeline_control_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_unit_pkg.sv
// pipeline_control_unit_pkg: shared state and command encodings for the pipeline sequencer.
package pipeline_control_unit_pkg;
    localparam int NB_CMD = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef enum logic [NB_CMD-1:0] {
        CMD_NOP   = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_PAUSE = 2'b11
    } cmd_t;
endpackage

// File: rtl/pipeline_control_unit_hazard_detector.sv
// hazard_detector: flags a load in EX whose destination feeds a source of the instruction in ID.
module hazard_detector #(
    parameter int NB_ADDR_REGISTERS = 5
) (
    input  logic [NB_ADDR_REGISTERS-1:0] i_id_rs,
    input  logic [NB_ADDR_REGISTERS-1:0] i_id_rt,
    input  logic                         i_id_uses_rt,
    input  logic [NB_ADDR_REGISTERS-1:0] i_ex_rt,
    input  logic                         i_ex_mem_read,
    output logic                         o_load_use
);
    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign o_load_use = i_ex_mem_read && (i_ex_rt != '0) &&
                        ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: run/step/pause/halt sequencer with load-use stall and branch flush control.
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int NB_ADDR_REGISTERS = 5,
    parameter int NB_CYCLE_COUNT    = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_cmd_valid,
    input  logic [NB_CMD-1:0]            i_cmd,
    output logic                         o_cmd_ready,
    input  logic                         i_halt_wb,
    input  logic [NB_ADDR_REGISTERS-1:0] i_id_rs,
    input  logic [NB_ADDR_REGISTERS-1:0] i_id_rt,
    input  logic                         i_id_uses_rt,
    input  logic [NB_ADDR_REGISTERS-1:0] i_ex_rt,
    input  logic                         i_ex_mem_read,
    input  logic                         i_branch_taken,
    output logic                         o_stage_en,
    output logic                         o_pc_en,
    output logic                         o_if_id_en,
    output logic                         o_if_id_flush,
    output logic                         o_id_ex_flush,
    output logic [1:0]                   o_state,
    output logic                         o_done,
    output logic [NB_CYCLE_COUNT-1:0]    o_cycle_count
);
    state_t state;
    logic   load_use;
    logic   accept;

    hazard_detector #(.NB_ADDR_REGISTERS(NB_ADDR_REGISTERS)) u_hazard (
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_id_uses_rt (i_id_uses_rt),
        .i_ex_rt      (i_ex_rt),
        .i_ex_mem_read(i_ex_mem_read),
        .o_load_use   (load_use)
    );

    assign o_state     = state;
    assign o_stage_en  = (state == ST_RUN) || (state == ST_STEP);
    assign o_cmd_ready = (state == ST_IDLE) || (state == ST_RUN);
    assign o_done      = (state == ST_DONE);
    assign accept      = i_cmd_valid && o_cmd_ready;

    // A stall holds PC and IF/ID and suppresses the branch flush until operands are fresh
    assign o_pc_en       = o_stage_en && !load_use;
    assign o_if_id_en    = o_stage_en && !load_use;
    assign o_id_ex_flush = o_stage_en && load_use;
    assign o_if_id_flush = o_stage_en && !load_use && i_branch_taken;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            o_cycle_count <= '0;
        end else begin
            if (o_stage_en && (o_cycle_count != '1))
                o_cycle_count <= o_cycle_count + NB_CYCLE_COUNT'(1);
            case (state)
                ST_IDLE: state <= !accept            ? ST_IDLE :
                                  (i_cmd == CMD_RUN)  ? ST_RUN  :
                                  (i_cmd == CMD_STEP) ? ST_STEP : ST_IDLE;
                ST_RUN:  state <= i_halt_wb                      ? ST_DONE :
                                  (accept && i_cmd == CMD_PAUSE) ? ST_IDLE : ST_RUN;
                ST_STEP: state <= i_halt_wb ? ST_DONE : ST_IDLE;
                default: state <= ST_DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb_pipeline_control_unit: directed and randomized checks against a behavioural sequencer model.
module tb_pipeline_control_unit;
    logic        clk = 0, rst_n = 0, valid = 0, halt = 0;
    logic [1:0]  cmd = 0;
    logic [4:0]  rs = 0, rt = 0, ex_rt = 0;
    logic        uses_rt = 0, mem_read = 0, br = 0;
    logic        cmd_ready, stage_en, pc_en, if_id_en, if_id_flush, id_ex_flush, done;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    // model: mode 0 idle, 1 run, 2 step, 3 done
    logic [1:0]  mode = 0;
    logic [31:0] m_count = 0;
    int n_chk = 0, n_fail = 0;

    pipeline_control_unit dut (
        .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready),
        .i_halt_wb(halt), .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rt(uses_rt), .i_ex_rt(ex_rt),
        .i_ex_mem_read(mem_read), .i_branch_taken(br), .o_stage_en(stage_en), .o_pc_en(pc_en),
        .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush), .o_id_ex_flush(id_ex_flush),
        .o_state(state), .o_done(done), .o_cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_vec();
        logic en, lu;
        en = (mode == 2'd1) || (mode == 2'd2);
        lu = mem_read && (ex_rt != 0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
        return {en, en && !lu, en && !lu, en && !lu && br, en && lu, mode, mode == 2'd3, mode <= 2'd1};
    endfunction

    function automatic logic [8:0] got_vec();
        return {stage_en, pc_en, if_id_en, if_id_flush, id_ex_flush, state, done, cmd_ready};
    endfunction

    task automatic tick();
        logic en, acc;
        en  = (mode == 2'd1) || (mode == 2'd2);
        acc = valid && (mode <= 2'd1);
        if (!rst_n) begin
            mode = 0;
            m_count = 0;
        end else begin
            if (en && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (en && halt) mode = 3;
            else if (mode == 2'd2) mode = 0;
            else if (mode == 2'd0 && acc && cmd == 2'b01) mode = 1;
            else if (mode == 2'd0 && acc && cmd == 2'b10) mode = 2;
            else if (mode == 2'd1 && acc && cmd == 2'b11) mode = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        valid = 1;
        cmd = c;
        tick();
        valid = 0;
        cmd = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        #1;
        n_chk++; if (got_vec() !== 9'b00000_00_0_1) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", got_vec(), 9'b000000001); end
        n_chk++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    endtask

    task automatic test_step();
        for (int i = 0; i < 3; i++) begin
            send(2'b10);
            n_chk++; if (stage_en !== 1'b1 || got_vec() !== exp_vec()) begin n_fail++; $display("FAIL step_active: got %b want %b", got_vec(), exp_vec()); end
            tick();
            n_chk++; if (state !== 2'd0 || cmd_ready !== 1'b1 || stage_en !== 1'b0) begin n_fail++; $display("FAIL step_idle: state %0d ready %b en %b want 0 1 0", state, cmd_ready, stage_en); end
        end
        n_chk++; if (cycle_count !== 32'd3) begin n_fail++; $display("FAIL step_count: got %0d want 3", cycle_count); end
    endtask

    task automatic test_run_pause();
        do_reset();
        send(2'b01);
        repeat (9) tick();
        send(2'b11);
        n_chk++; if (cycle_count !== 32'd10 || stage_en !== 1'b0) begin n_fail++; $display("FAIL pause_count: got %0d en %b want 10 0", cycle_count, stage_en); end
        send(2'b01);
        repeat (3) tick();
        n_chk++; if (cycle_count !== 32'd13 || state !== 2'd1) begin n_fail++; $display("FAIL resume_count: got %0d state %0d want 13 1", cycle_count, state); end
    endtask

    task automatic test_hazard();
        mem_read = 1; ex_rt = 5; rs = 5; rt = 0; uses_rt = 0; br = 0;
        #1;
        n_chk++; if ({pc_en, if_id_en, id_ex_flush} !== 3'b001) begin n_fail++; $display("FAIL load_use_rs: got %b want 001", {pc_en, if_id_en, id_ex_flush}); end
        ex_rt = 0; rs = 0;
        #1;
        n_chk++; if ({pc_en, if_id_en, id_ex_flush} !== 3'b110) begin n_fail++; $display("FAIL load_r0: got %b want 110", {pc_en, if_id_en, id_ex_flush}); end
        ex_rt = 9; rs = 3; rt = 9; uses_rt = 1;
        #1;
        n_chk++; if (id_ex_flush !== 1'b1 || pc_en !== 1'b0) begin n_fail++; $display("FAIL load_use_rt: flush %b pc %b want 1 0", id_ex_flush, pc_en); end
        uses_rt = 0;
        #1;
        n_chk++; if (id_ex_flush !== 1'b0) begin n_fail++; $display("FAIL rt_unused: flush %b want 0", id_ex_flush); end
        ex_rt = 5; rs = 5; br = 1;
        #1;
        n_chk++; if ({pc_en, if_id_flush, id_ex_flush} !== 3'b001) begin n_fail++; $display("FAIL stall_over_branch: got %b want 001", {pc_en, if_id_flush, id_ex_flush}); end
        tick();
        mem_read = 0;
        #1;
        n_chk++; if ({pc_en, if_id_en, if_id_flush, id_ex_flush} !== 4'b1110) begin n_fail++; $display("FAIL branch_flush: got %b want 1110", {pc_en, if_id_en, if_id_flush, id_ex_flush}); end
        br = 0; ex_rt = 0; rs = 0; rt = 0;
    endtask

    task automatic test_halt();
        logic [31:0] c;
        c = cycle_count;
        halt = 1; valid = 1; cmd = 2'b11;
        tick();
        halt = 0; valid = 0; cmd = 0;
        n_chk++; if ({state, done, cmd_ready, stage_en} !== 5'b11100) begin n_fail++; $display("FAIL halt_done: got %b want 11100", {state, done, cmd_ready, stage_en}); end
        n_chk++; if (cycle_count !== c + 1) begin n_fail++; $display("FAIL halt_count: got %0d want %0d", cycle_count, c + 1); end
        send(2'b01);
        tick();
        n_chk++; if (state !== 2'd3 || stage_en !== 1'b0) begin n_fail++; $display("FAIL done_sticky: state %0d en %b want 3 0", state, stage_en); end
        do_reset();
        n_chk++; if (state !== 2'd0 || cycle_count !== 32'd0) begin n_fail++; $display("FAIL done_reset: state %0d count %0d want 0 0", state, cycle_count); end
        halt = 1;
        tick();
        halt = 0;
        n_chk++; if (state !== 2'd0 || done !== 1'b0) begin n_fail++; $display("FAIL halt_idle_ignored: state %0d done %b want 0 0", state, done); end
    endtask

    task automatic test_reset_during_step();
        send(2'b01);
        repeat (4) tick();
        send(2'b11);
        send(2'b10);
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        n_chk++; if (got_vec() !== 9'b000000001 || cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_in_step: got %b count %0d want 000000001 0", got_vec(), cycle_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 39) != 0);
            valid    = $urandom_range(0, 1);
            cmd      = 2'($urandom_range(0, 3));
            halt     = ($urandom_range(0, 29) == 0);
            rs       = 5'($urandom_range(0, 3));
            rt       = 5'($urandom_range(0, 3));
            ex_rt    = 5'($urandom_range(0, 3));
            uses_rt  = $urandom_range(0, 1);
            mem_read = $urandom_range(0, 1);
            br       = $urandom_range(0, 1);
            #1;
            n_chk++; if (got_vec() !== exp_vec()) begin n_fail++; $display("FAIL random_outputs[%0d]: got %b want %b", i, got_vec(), exp_vec()); end
            tick();
            n_chk++; if (cycle_count !== m_count) begin n_fail++; $display("FAIL random_count[%0d]: got %0d want %0d", i, cycle_count, m_count); end
        end
        rst_n = 1; valid = 0; halt = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_step();
        test_run_pause();
        test_hazard();
        test_halt();
        test_reset_during_step();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
